if_stage_q: RTL and testbench

Parametrised instruction-fetch stage with a decoupling fetch queue. It drives a synchronous instruction memory with one-cycle read latency and buffers returned instructions with their PCs in a FIFO. It presents them to decode with a valid/stall handshake, and on flush redirects to a branch target while discarding all queued and in-flight fetches. It sits between the PC/branch resolution logic and the ID stage.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_stage_q_fetch_queue.sv | 73 +++++++
 rtl/if_stage_q.sv | 115 +++++++++++
 tb/tb_if_stage_q.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch stage and its fetch queue.
package if_pkg;

    localparam int unsigned IF_XLEN = 32;
    localparam logic [IF_XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
    } fq_entry_t;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int unsigned fq_count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_stage_q_fetch_queue.sv
// Synchronous FIFO of fetch entries with wrap-around pointers; clear beats push and pop.
module fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = fq_count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  fq_entry_t        push_data,
    input  logic             pop,
    output fq_entry_t        head,
    output logic [CNT_W-1:0] count
);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;
    logic             empty, full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_stage_q.sv
// Instruction-fetch stage: drives a one-cycle-latency imem and buffers responses for decode.
// Optional performance counters are built when IF_PERF_EN is defined.
module if_stage_q
    import if_pkg::*;
#(
    parameter int unsigned        XLEN      = IF_XLEN,
    parameter logic [XLEN-1:0]    RESET_PC  = 32'h0000_0000,
    parameter int unsigned        FQ_DEPTH  = 4,
    parameter logic [XLEN-1:0]    NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 is_flush,
    input  logic                                 is_stall,
    input  logic [XLEN-1:0]                      branch_target,
    output logic                                 imem_req,
    output logic [XLEN-1:0]                      imem_addr,
    input  logic [XLEN-1:0]                      imem_rdata,
    output logic                                 is_valid,
    output logic [XLEN-1:0]                      pc,
    output logic [XLEN-1:0]                      instr,
    output logic [fq_count_width(FQ_DEPTH)-1:0]  fq_count,
    output logic [31:0]                          perf_fetch_cnt,
    output logic [31:0]                          perf_flush_cnt
);

    localparam int unsigned CNT_W = fq_count_width(FQ_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q;
    logic            inflight_q;
    logic            pop, push;
    logic [CNT_W:0]  occupancy;
    fq_entry_t       push_entry;
    fq_entry_t       head;
    logic            unused_target_bits;

    assign unused_target_bits = ^branch_target[1:0];

    assign is_valid = (fq_count != '0);
    assign pop      = is_valid & ~is_stall & ~is_flush;
    assign push     = inflight_q & ~is_flush;

    // Slots committed after this cycle: queued plus in flight, minus the entry leaving now.
    assign occupancy = {1'b0, fq_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign imem_req  = ~reset & ~is_flush & (occupancy < (CNT_W + 1)'(FQ_DEPTH));
    assign imem_addr = fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (is_flush) begin
            fetch_pc_d = {branch_target[XLEN-1:2], 2'b00};
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            req_addr_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= imem_req;
            if (imem_req) begin
                req_addr_q <= imem_addr;
            end
        end
    end

    assign push_entry.pc    = req_addr_q;
    assign push_entry.instr = imem_rdata;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (is_flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fq_count)
    );

    assign pc    = is_valid ? head.pc : '0;
    assign instr = is_valid ? head.instr : NOP_INSTR;

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (push) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (is_flush) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage_q.sv
// Directed-vector bench for if_stage_q with a one-cycle imem model (rdata = addr ^ A5A5_0000).
module tb_if_stage_q;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, is_flush, is_stall;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        is_valid;
    logic [31:0] pc, instr;
    logic [2:0]  fq_count;
    logic [31:0] perf_fetch_cnt, perf_flush_cnt;

    logic        reset_w;
    logic        imem_req_w;
    logic [31:0] imem_addr_w, imem_rdata_w;
    logic        is_valid_w;
    logic [31:0] pc_w, instr_w;
    logic [2:0]  fq_count_w;
    logic [31:0] perf_fetch_w, perf_flush_w;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    if_stage_q #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .is_flush       (is_flush),
        .is_stall       (is_stall),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .is_valid       (is_valid),
        .pc             (pc),
        .instr          (instr),
        .fq_count       (fq_count),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    if_stage_q #(
        .RESET_PC (32'hFFFF_FFF8),
        .FQ_DEPTH (4)
    ) dut_w (
        .clk            (clk),
        .reset          (reset_w),
        .is_flush       (1'b0),
        .is_stall       (1'b0),
        .branch_target  (32'h0),
        .imem_req       (imem_req_w),
        .imem_addr      (imem_addr_w),
        .imem_rdata     (imem_rdata_w),
        .is_valid       (is_valid_w),
        .pc             (pc_w),
        .instr          (instr_w),
        .fq_count       (fq_count_w),
        .perf_fetch_cnt (perf_fetch_w),
        .perf_flush_cnt (perf_flush_w)
    );

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ K;
        if (imem_req_w) imem_rdata_w <= imem_addr_w ^ K;
    end

    // Overflow can never happen; flag it if the queue ever reports more than its depth.
    always @(negedge clk) begin
        if (!reset && fq_count > 3'd4) begin
            miscompares++;
            $display("FAIL overflow fq_count=%0d limit=4", fq_count);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; is_flush = 1'b0; is_stall = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; is_flush = 1'b0; is_stall = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (is_valid !== 1'b0 || pc !== 32'h0 || instr !== NOP) begin
            miscompares++;
            $display("FAIL reset_head got v=%b pc=%h instr=%h want v=0 pc=0 instr=%h",
                     is_valid, pc, instr, NOP);
        end
        vectors++;
        if (fq_count !== 3'd0 || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got cnt=%0d req=%b want cnt=0 req=0", fq_count, imem_req);
        end
        vectors++;
        if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_flush_cnt);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin
                miscompares++;
                $display("FAIL stream_req c=%0d got req=%b addr=%h want req=1 addr=%h",
                         c, imem_req, imem_addr, 32'(4 * c));
            end
            vectors++;
            if (c < 2) begin
                if (is_valid !== 1'b0 || pc !== 32'h0 || instr !== NOP) begin
                    miscompares++;
                    $display("FAIL stream_idle c=%0d got v=%b pc=%h instr=%h want v=0 pc=0",
                             c, is_valid, pc, instr);
                end
            end else begin
                exp_pc = 32'(4 * (c - 2));
                if (is_valid !== 1'b1 || pc !== exp_pc || instr !== (exp_pc ^ K)) begin
                    miscompares++;
                    $display("FAIL stream_head c=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                             c, is_valid, pc, instr, exp_pc, exp_pc ^ K);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            is_stall = (c >= 4 && c <= 12);
            @(negedge clk);
            if (c >= 2) begin
                if (c < 4) exp_pc = 32'(4 * (c - 2));
                else if (c <= 12) exp_pc = 32'h8;
                else exp_pc = 32'(8 + 4 * (c - 13));
                vectors++;
                if (is_valid !== 1'b1 || pc !== exp_pc || instr !== (exp_pc ^ K)) begin
                    miscompares++;
                    $display("FAIL stall_head c=%0d got v=%b pc=%h instr=%h want pc=%h instr=%h",
                             c, is_valid, pc, instr, exp_pc, exp_pc ^ K);
                end
            end
            if (c >= 4 && c <= 12) begin
                exp_cnt = (c >= 7) ? 3'd4 : 3'(c - 3);
                vectors++;
                if (fq_count !== exp_cnt || imem_req !== (c < 6)) begin
                    miscompares++;
                    $display("FAIL stall_fill c=%0d got cnt=%0d req=%b want cnt=%0d req=%b",
                             c, fq_count, imem_req, exp_cnt, c < 6);
                end
            end
            next_cycle();
        end
        is_stall = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] exp_pc;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            is_stall      = (c >= 4 && c <= 6);
            is_flush      = (c == 6);
            branch_target = 32'h0000_0022;
            @(negedge clk);
            if (c == 6) begin
                vectors++;
                if (fq_count !== 3'd3 || imem_req !== 1'b0 || pc !== 32'h8) begin
                    miscompares++;
                    $display("FAIL flush_pre got cnt=%0d req=%b pc=%h want cnt=3 req=0 pc=8",
                             fq_count, imem_req, pc);
                end
            end else if (c == 7 || c == 8) begin
                vectors++;
                if (is_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'(32 + 4 * (c - 7))) begin
                    miscompares++;
                    $display("FAIL flush_gap c=%0d got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
                             c, is_valid, imem_req, imem_addr, 32'(32 + 4 * (c - 7)));
                end
            end else if (c >= 9) begin
                exp_pc = 32'(32 + 4 * (c - 9));
                vectors++;
                if (is_valid !== 1'b1 || pc !== exp_pc || instr !== (exp_pc ^ K)) begin
                    miscompares++;
                    $display("FAIL flush_head c=%0d got v=%b pc=%h instr=%h want pc=%h",
                             c, is_valid, pc, instr, exp_pc);
                end
            end
            next_cycle();
        end
        is_flush = 1'b0;
        is_stall = 1'b0;
    endtask

    task automatic test_flush_full();
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            is_stall      = (c >= 4 && c <= 9);
            is_flush      = (c == 10);
            branch_target = 32'h0000_0100;
            @(negedge clk);
            if (c == 10) begin
                vectors++;
                if (fq_count !== 3'd4 || imem_req !== 1'b0 || is_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL fullflush_pre got cnt=%0d req=%b v=%b want cnt=4 req=0 v=1",
                             fq_count, imem_req, is_valid);
                end
            end else if (c == 11) begin
                vectors++;
                if (fq_count !== 3'd0 || is_valid !== 1'b0 || imem_addr !== 32'h100) begin
                    miscompares++;
                    $display("FAIL fullflush_empty got cnt=%0d v=%b addr=%h want cnt=0 v=0 addr=100",
                             fq_count, is_valid, imem_addr);
                end
            end else if (c == 13) begin
                vectors++;
                if (is_valid !== 1'b1 || pc !== 32'h100 || instr !== (32'h100 ^ K)) begin
                    miscompares++;
                    $display("FAIL fullflush_head got v=%b pc=%h instr=%h want v=1 pc=100",
                             is_valid, pc, instr);
                end
            end
            next_cycle();
        end
        is_flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            is_stall = (c >= 4);
            reset    = (c == 8 || c == 9);
            @(negedge clk);
            if (c == 8) begin
                vectors++;
                if (fq_count !== 3'd4) begin
                    miscompares++;
                    $display("FAIL midreset_full got cnt=%0d want 4", fq_count);
                end
            end else if (c == 9) begin
                vectors++;
                if (is_valid !== 1'b0 || pc !== 32'h0 || instr !== NOP || fq_count !== 3'd0
                    || imem_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midreset_vals got v=%b pc=%h instr=%h cnt=%0d req=%b want 0/0/%h/0/0",
                             is_valid, pc, instr, fq_count, imem_req, NOP);
                end
            end else if (c == 10) begin
                vectors++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                    miscompares++;
                    $display("FAIL midreset_restart got req=%b addr=%h want req=1 addr=0",
                             imem_req, imem_addr);
                end
            end
            next_cycle();
        end
        is_stall = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        reset_w = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_w = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                exp_pc = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
                vectors++;
                if (is_valid_w !== 1'b1 || pc_w !== exp_pc || instr_w !== (exp_pc ^ K)) begin
                    miscompares++;
                    $display("FAIL wrap_head c=%0d got v=%b pc=%h instr=%h want pc=%h instr=%h",
                             c, is_valid_w, pc_w, instr_w, exp_pc, exp_pc ^ K);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_fetch, exp_flush;
`ifdef IF_PERF_EN
        exp_fetch = 32'd10;
        exp_flush = 32'd2;
`else
        exp_fetch = 32'd0;
        exp_flush = 32'd0;
`endif
        do_reset();
        for (int c = 0; c <= 13; c++) begin
            is_flush      = (c == 11 || c == 12);
            branch_target = 32'h0000_0040;
            @(negedge clk);
            if (c == 13) begin
                vectors++;
                if (perf_fetch_cnt !== exp_fetch || perf_flush_cnt !== exp_flush) begin
                    miscompares++;
                    $display("FAIL perf got %0d/%0d want %0d/%0d",
                             perf_fetch_cnt, perf_flush_cnt, exp_fetch, exp_flush);
                end
            end
            next_cycle();
        end
        is_flush = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        reset_w       = 1'b1;
        is_flush      = 1'b0;
        is_stall      = 1'b0;
        branch_target = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_full();
        test_reset_mid();
        test_wrap();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
